// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier sequencer.
package mul_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } state_e;

  // Counter width; kept at least 1 so a degenerate WIDTH still elaborates.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Operand capture, magnitude/sign handling, the single shared adder and the result register.
// One add/shift per step strobe; no backpressure, the FSM fully schedules every strobe.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               sgn_q, sgn_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] sum;

  // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign mag_a = (sgn_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
  assign mag_b = (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;
  assign sum   = acc_q + mcand_q;

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;

    if (capture) begin
      a_d   = a;
      b_d   = b;
      sgn_d = op_signed;
    end

    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      neg_d    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    end

    if (step) begin
      if (mplier_q[0]) acc_d = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end

    // Negating a zero accumulator wraps back to zero, so no -0 can appear.
    if (fix) product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: rtl/mul_sequencer.sv
// FSM sequencing an 8x8 shift-and-add multiply: PREP, WIDTH x CALC, FIX, DONE (done at start+WIDTH+3).
// No backpressure: start is accepted only in IDLE/DONE and ignored while busy.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture, load, step, fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        load    = 1'b1;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = ST_CALC;
      end
      ST_CALC: begin
        // Always runs WIDTH iterations so latency is independent of the operands.
        step = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          capture = 1'b1;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_PREP) || (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (capture),
    .load     (load),
    .step     (step),
    .fix      (fix),
    .op_signed(op_signed),
    .a        (a),
    .b        (b),
    .product  (product)
  );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer with hand-computed products and cycle timing.
module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_signed;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int tests;
  int fails;

  mul_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_signed(op_signed),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and let the accepting edge pass; afterwards we are in cycle N+1.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    a = av;
    b = bv;
    op_signed = sv;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op_signed = 1'b0;
    a = '0;
    b = '0;
    #12;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL reset_product got=%h exp=0000", product); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_unsigned_max();
    issue(8'hFF, 8'hFF, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tests++;
      if (busy !== (k <= 10)) begin fails++; $display("FAIL uns_ff_busy cycle=%0d got=%b exp=%b", k, busy, (k <= 10)); end
      tests++;
      if (done !== (k == 11)) begin fails++; $display("FAIL uns_ff_done cycle=%0d got=%b exp=%b", k, done, (k == 11)); end
      if (k >= 11) begin
        tests++;
        if (product !== 16'hFE01) begin fails++; $display("FAIL uns_ff_product cycle=%0d got=%h exp=fe01", k, product); end
      end
      step();
    end
  endtask

  task automatic test_signed_min();
    logic [7:0]  av [2];
    logic [7:0]  bv [2];
    logic [15:0] pv [2];
    av = '{8'h80, 8'h80};
    bv = '{8'h7F, 8'h80};
    pv = '{16'hC080, 16'h4000};
    for (int t = 0; t < 2; t++) begin
      issue(av[t], bv[t], 1'b1);
      for (int k = 1; k <= 11; k++) begin
        if (k == 10) begin
          tests++;
          if (done !== 1'b0) begin fails++; $display("FAIL sgn_min_early_done op=%0d got=%b exp=0", t, done); end
        end
        if (k == 11) begin
          tests++;
          if (done !== 1'b1) begin fails++; $display("FAIL sgn_min_done op=%0d got=%b exp=1", t, done); end
          tests++;
          if (product !== pv[t]) begin fails++; $display("FAIL sgn_min_product op=%0d got=%h exp=%h", t, product, pv[t]); end
        end
        step();
      end
    end
  endtask

  task automatic test_signed_small();
    logic [15:0] pv [2];
    pv = '{16'hFFF1, 16'h04F1};
    for (int t = 0; t < 2; t++) begin
      issue(8'hFD, 8'h05, (t == 0));
      for (int k = 1; k <= 11; k++) begin
        // Flip op_signed and the operands mid-calculation; the latched values must win.
        if (k == 4) begin
          op_signed = ~op_signed;
          a = 8'h11;
          b = 8'h22;
        end
        if (k == 11) begin
          tests++;
          if (done !== 1'b1) begin fails++; $display("FAIL small_done op=%0d got=%b exp=1", t, done); end
          tests++;
          if (product !== pv[t]) begin fails++; $display("FAIL small_product op=%0d got=%h exp=%h", t, product, pv[t]); end
        end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic exp_busy, exp_done;
    pulses = 0;
    a = 8'h0C;
    b = 8'h0A;
    op_signed = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      start = (k <= 30);
      step();
      exp_busy = (k <= 10) || (k >= 12 && k <= 21) || (k >= 23 && k <= 32);
      exp_done = (k == 11) || (k == 22) || (k == 33);
      if (done === 1'b1) pulses++;
      if (busy !== exp_busy) begin
        tests++; fails++;
        $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", k, busy, exp_busy);
      end
      if (done !== exp_done) begin
        tests++; fails++;
        $display("FAIL b2b_done cycle=%0d got=%b exp=%b", k, done, exp_done);
      end
      if (k == 11 || k == 22 || k == 33) begin
        tests++;
        if (product !== 16'h0078) begin fails++; $display("FAIL b2b_product cycle=%0d got=%h exp=0078", k, product); end
      end
    end
    start = 1'b0;
    tests++;
    if (pulses != 3) begin fails++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
  endtask

  task automatic test_reset_mid();
    issue(8'hFF, 8'hFF, 1'b0);
    for (int k = 1; k < 5; k++) step();
    // Cycle 5 of the operation: drop reset between edges.
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arst_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL arst_done got=%b exp=0", done); end
    tests++; if (product !== 16'h0000) begin fails++; $display("FAIL arst_product got=%h exp=0000", product); end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL arst_resume cycle=%0d busy=%b done=%b exp=0/0", k, busy, done);
      end
    end
    issue(8'h02, 8'h03, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL arst_after_done got=%b exp=1", done); end
        tests++;
        if (product !== 16'h0006) begin fails++; $display("FAIL arst_after_product got=%h exp=0006", product); end
      end
      step();
    end
  endtask

  task automatic test_zero();
    issue(8'h00, 8'hFF, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      tests++;
      if (busy !== (k <= 10)) begin fails++; $display("FAIL zero_busy cycle=%0d got=%b exp=%b", k, busy, (k <= 10)); end
      if (k == 11) begin
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL zero_done got=%b exp=1", done); end
        tests++;
        if (product !== 16'h0000) begin fails++; $display("FAIL zero_product got=%h exp=0000", product); end
      end
      step();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_unsigned_max();
    test_signed_min();
    test_signed_small();
    test_back_to_back();
    test_reset_mid();
    test_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
